apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter that shares the single APB master front-end between `NUM_REQ` independent requesters (DMA, CPU bridge, test sequencer). It accepts per-requester transfer requests, grants one at a time, drives the master's command side (`valid/addr/write/wdata/strb/prot/sels`), and returns `ready/rdata/master_error` to the granted requester only. At most one APB transfer is ever outstanding.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, `` `APB_ADDR_WIDTH ``, address width
- `DATA_WIDTH`, `` `APB_DATA_WIDTH ``, data width; strobe width is `DATA_WIDTH/8`
- `SEL_WIDTH`, `$clog2(`APB_SLAVE_DEVICES)+1`, slave-select width
- `TIMEOUT_CYCLES`, 256, watchdog limit (only with `APB_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rstn`  in  1  synchronous reset, active-low
- `req_valid`  in  NUM_REQ  per-requester request; held until its `req_done`
- `req_addr / req_wdata / req_strb / req_prot / req_sels / req_write`  in  NUM_REQ×field width, packed  per-requester command fields; stable while `req_valid`
- `req_done`  out  NUM_REQ  one-cycle completion pulse, one-hot
- `req_rdata`  out  DATA_WIDTH  read data, valid only with `req_done`
- `req_error`  out  1  error qualifier, valid only with `req_done`
- `m_valid, m_addr, m_write, m_wdata, m_strb, m_prot, m_sels`  out  master widths  command to the APB master front-end
- `m_ready`  in  1  one-cycle transfer-complete pulse from the master
- `m_rdata`  in  DATA_WIDTH  read data, valid with `m_ready`
- `m_error`  in  1  `master_error`, valid with `m_ready`
- `m_abort`  out  1  drives master `other_error`; see Configuration
- `grant_id`  out  $clog2(NUM_REQ)  index of current/last grant

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any `req_valid`, select winner by round-robin starting at `last+1` (mod NUM_REQ), latch its command fields into registers, set `grant_id`, update `last`, go BUSY. No request → stay IDLE.
- BUSY: `m_valid`=1, `m_*` driven from latched registers (requester field changes ignored). On `m_ready`=1: latch `m_rdata`, `m_error`, go RESP.
- RESP: `req_done[grant_id]`=1 for exactly one cycle with latched `req_rdata/req_error`; `m_valid`=0; go IDLE.
- Requester may keep `req_valid` high after `req_done` to request another transfer; it rejoins arbitration with lowest priority relative to others.
- `m_ready` outside BUSY ignored. Withdrawn `req_valid` after grant: transfer still completes, `req_done` still pulses.
- Reset values: state IDLE, `last`=NUM_REQ-1 (so requester 0 wins first), `m_valid`=0, all `m_*`=0, `req_done`=0, `req_rdata`=0, `req_error`=0, `m_abort`=0, `grant_id`=0.
- Reset mid-BUSY: all outputs return to reset values next edge; the pending transfer is dropped silently (no `req_done`).

## Timing
- All outputs registered.
- `req_valid` first high at edge N (state IDLE) → `m_valid`=1 from edge N+1.
- `m_ready` sampled at edge K → `m_valid`=0 and `req_done`=1 from edge K+1 → IDLE at K+2 → next `m_valid` earliest K+3.
- Minimum per-transfer occupancy: 3 cycles plus the master's wait states.
- Fairness: with all requesters continuously valid, grants follow 0,1,…,NUM_REQ-1,0,….

## Configuration
- `APB_ARB_TIMEOUT_EN` defined: a counter clears on BUSY entry and increments each BUSY cycle. On reaching `TIMEOUT_CYCLES` without `m_ready`: `m_abort`=1 for one cycle, `m_valid` drops, FSM enters RESP, and `req_done` pulses with `req_error`=1, `req_rdata`=0.
- Undefined: no counter; `m_abort` tied 0; BUSY waits indefinitely.

## Structure
- `apb_arb_pkg`: FSM state enum, `SEL_WIDTH`/`STRB_WIDTH` localparams, packed command struct (addr, write, wdata, strb, prot, sels).
- One sub-module `rr_arbiter`: combinational rotate-priority select from `req_valid` and `last`, outputs one-hot grant and index. The pointer register stays in the top.

## Test plan
- Single request: requester 2 valid, write addr 0x100 data 0xDEADBEEF → `m_valid` next cycle with those fields; `m_ready` after 2 waits → `req_done[2]` one cycle later, `req_error`=0.
- All 4 requesters continuously valid for 8 transfers → grant order 0,1,2,3,0,1,2,3; no gap shorter than 3 cycles.
- Read with `m_rdata`=0x12345678, `m_error`=1 → `req_rdata`=0x12345678, `req_error`=1, only the granted `req_done` bit set.
- Requester changes `req_addr` from 0x10 to 0x20 during BUSY → `m_addr` stays 0x10.
- `rstn`=0 for one cycle in BUSY → all outputs reset next edge, no `req_done`; next grant goes to requester 0.
- With `APB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `m_ready` never asserted → `m_abort` pulse after 16 BUSY cycles, `req_done` with `req_error`=1, `req_rdata`=0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB requester arbiter: FSM state encoding, derived
// field widths and the packed command record latched at grant time.
// Width defaults come from APB_ADDR_WIDTH / APB_DATA_WIDTH / APB_SLAVE_DEVICES
// when the surrounding build does not provide them.

`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_SLAVE_DEVICES
`define APB_SLAVE_DEVICES 4
`endif

package apb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int ARB_ADDR_W = `APB_ADDR_WIDTH;
    localparam int ARB_DATA_W = `APB_DATA_WIDTH;
    localparam int STRB_WIDTH = ARB_DATA_W / 8;
    localparam int SEL_WIDTH  = $clog2(`APB_SLAVE_DEVICES) + 1;
    localparam int PROT_WIDTH = 3;

    // Command fields captured from the winning requester.
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  write;
        logic [ARB_DATA_W-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [PROT_WIDTH-1:0] prot;
        logic [SEL_WIDTH-1:0]  sels;
    } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority selector. The search starts one past the
// last granted index, so the previous winner has the lowest priority.

module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    // Walk the requesters in rotated order and take the first one asserted.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int cand;
            cand = (int'(last_i) + i) % NUM_REQ;
            if (!any_o && req_i[IDX_W'(cand)]) begin
                any_o                   = 1'b1;
                gnt_idx_o               = IDX_W'(cand);
                gnt_oh_o[IDX_W'(cand)]  = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master front-end between NUM_REQ
// requesters. One transfer outstanding at a time: IDLE picks a winner and
// latches its command, BUSY presents it to the master until m_ready, RESP
// pulses the winner's req_done with the captured response.
// Optional watchdog: define APB_ARB_TIMEOUT_EN to abort a transfer that
// sees no m_ready within TIMEOUT_CYCLES BUSY cycles.

module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
    parameter int SEL_WIDTH      = $clog2(`APB_SLAVE_DEVICES) + 1,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IDX_W         = $clog2(NUM_REQ),
    localparam int STRB_W        = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]     req_strb,
    input  logic [NUM_REQ*3-1:0]          req_prot,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sels,
    input  logic [NUM_REQ-1:0]            req_write,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_error,
    output logic                          m_valid,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic                          m_write,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [STRB_W-1:0]             m_strb,
    output logic [2:0]                    m_prot,
    output logic [SEL_WIDTH-1:0]          m_sels,
    input  logic                          m_ready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_error,
    output logic                          m_abort,
    output logic [IDX_W-1:0]              grant_id
);

    arb_state_e             state_q,     state_d;
    logic [IDX_W-1:0]       last_q,      last_d;
    logic [IDX_W-1:0]       grant_id_q,  grant_id_d;
    logic [NUM_REQ-1:0]     grant_oh_q,  grant_oh_d;
    apb_cmd_t               cmd_q,       cmd_d;
    logic                   m_valid_q,   m_valid_d;
    logic [NUM_REQ-1:0]     req_done_q,  req_done_d;
    logic [DATA_WIDTH-1:0]  req_rdata_q, req_rdata_d;
    logic                   req_error_q, req_error_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]       tmo_cnt_q,   tmo_cnt_d;
    logic                   m_abort_q,   m_abort_d;
`endif

    logic [NUM_REQ-1:0]     arb_oh_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   arb_any_s;
    apb_cmd_t               sel_cmd_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_oh_o  (arb_oh_s),
        .gnt_idx_o (arb_idx_s),
        .any_o     (arb_any_s)
    );

    // Gather the candidate winner's command fields out of the packed buses.
    always_comb begin
        sel_cmd_s       = '0;
        sel_cmd_s.addr  = req_addr [arb_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cmd_s.write = req_write[arb_idx_s];
        sel_cmd_s.wdata = req_wdata[arb_idx_s*DATA_WIDTH +: DATA_WIDTH];
        sel_cmd_s.strb  = req_strb [arb_idx_s*STRB_W     +: STRB_W];
        sel_cmd_s.prot  = req_prot [arb_idx_s*3          +: 3];
        sel_cmd_s.sels  = req_sels [arb_idx_s*SEL_WIDTH  +: SEL_WIDTH];
    end

    // Next-state and next-output logic for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_id_d  = grant_id_q;
        grant_oh_d  = grant_oh_q;
        cmd_d       = cmd_q;
        m_valid_d   = m_valid_q;
        req_done_d  = '0;
        req_rdata_d = req_rdata_q;
        req_error_d = req_error_q;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        m_abort_d   = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (arb_any_s) begin
                    state_d    = ARB_BUSY;
                    cmd_d      = sel_cmd_s;
                    grant_id_d = arb_idx_s;
                    grant_oh_d = arb_oh_s;
                    last_d     = arb_idx_s;
                    m_valid_d  = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end else begin
                    state_d    = ARB_IDLE;
                    m_valid_d  = 1'b0;
                end
            end
            ARB_BUSY: begin
                if (m_ready) begin
                    state_d     = ARB_RESP;
                    m_valid_d   = 1'b0;
                    req_done_d  = grant_oh_q;
                    req_rdata_d = m_rdata;
                    req_error_d = m_error;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Master never answered: release the requester with an error.
                    state_d     = ARB_RESP;
                    m_valid_d   = 1'b0;
                    m_abort_d   = 1'b1;
                    req_done_d  = grant_oh_q;
                    req_rdata_d = '0;
                    req_error_d = 1'b1;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
                end
`else
                else begin
                    state_d     = ARB_BUSY;
                end
`endif
            end
            ARB_RESP: begin
                state_d   = ARB_IDLE;
                m_valid_d = 1'b0;
            end
            default: begin
                state_d   = ARB_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ARB_IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            grant_id_q  <= '0;
            grant_oh_q  <= '0;
            cmd_q       <= '0;
            m_valid_q   <= 1'b0;
            req_done_q  <= '0;
            req_rdata_q <= '0;
            req_error_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            m_abort_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_id_q  <= grant_id_d;
            grant_oh_q  <= grant_oh_d;
            cmd_q       <= cmd_d;
            m_valid_q   <= m_valid_d;
            req_done_q  <= req_done_d;
            req_rdata_q <= req_rdata_d;
            req_error_q <= req_error_d;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            m_abort_q   <= m_abort_d;
`endif
        end
    end

    assign m_valid   = m_valid_q;
    assign m_addr    = cmd_q.addr;
    assign m_write   = cmd_q.write;
    assign m_wdata   = cmd_q.wdata;
    assign m_strb    = cmd_q.strb;
    assign m_prot    = cmd_q.prot;
    assign m_sels    = cmd_q.sels;
    assign req_done  = req_done_q;
    assign req_rdata = req_rdata_q;
    assign req_error = req_error_q;
    assign grant_id  = grant_id_q;
`ifdef APB_ARB_TIMEOUT_EN
    assign m_abort   = m_abort_q;
`else
    assign m_abort   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a vector table of transfers (request
// mask, expected winner, command fields, master response) plus hand-written
// sequences for field freezing, request withdrawal, reset during BUSY and the
// stall/timeout behaviour.

module tb_apb_req_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 3;
    localparam int SBW = DW / 8;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SBW-1:0] req_strb;
    logic [NR*3-1:0]   req_prot;
    logic [NR*SW-1:0]  req_sels;
    logic [NR-1:0]     req_write;
    logic [NR-1:0]     req_done;
    logic [DW-1:0]     req_rdata;
    logic              req_error;
    logic              m_valid;
    logic [AW-1:0]     m_addr;
    logic              m_write;
    logic [DW-1:0]     m_wdata;
    logic [SBW-1:0]    m_strb;
    logic [2:0]        m_prot;
    logic [SW-1:0]     m_sels;
    logic              m_ready;
    logic [DW-1:0]     m_rdata;
    logic              m_error;
    logic              m_abort;
    logic [1:0]        grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot), .req_sels(req_sels),
        .req_write(req_write), .req_done(req_done), .req_rdata(req_rdata),
        .req_error(req_error), .m_valid(m_valid), .m_addr(m_addr),
        .m_write(m_write), .m_wdata(m_wdata), .m_strb(m_strb),
        .m_prot(m_prot), .m_sels(m_sels), .m_ready(m_ready),
        .m_rdata(m_rdata), .m_error(m_error), .m_abort(m_abort),
        .grant_id(grant_id)
    );

    typedef struct {
        logic [NR-1:0] mask;
        int            exp;
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        int            waits;
        logic [31:0]   rdata;
        logic          err;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NR-1:0] mask, input int exp, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int waits, input logic [31:0] rdata, input logic err);
        vec_t v;
        v.mask = mask; v.exp = exp; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.waits = waits; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    // Winner gets the vector's fields; everyone else gets distinct decoys.
    task automatic set_fields(input vec_t v);
        for (int i = 0; i < NR; i++) begin
            req_addr [i*AW +: AW]   = (i == v.exp) ? v.addr  : (32'hF000_0000 | 32'(i));
            req_wdata[i*DW +: DW]   = (i == v.exp) ? v.wdata : ~v.wdata;
            req_write[i]            = (i == v.exp) ? v.wr    : ~v.wr;
            req_strb [i*SBW +: SBW] = 4'b0001 << i;
            req_prot [i*3 +: 3]     = 3'(i);
            req_sels [i*SW +: SW]   = 3'(i + 1);
        end
    endtask

    // Wait (bounded) for m_valid; req_done must stay low meanwhile.
    task automatic wait_mvalid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (m_valid !== 1'b1) chk("done_low_while_waiting", 64'(req_done), 64'd0);
        end while (m_valid !== 1'b1 && cyc < 20);
        chk("m_valid_seen", 64'(m_valid), 64'd1);
    endtask

    task automatic pulse_ready(input logic [31:0] rd, input logic er);
        m_ready = 1'b1; m_rdata = rd; m_error = er;
        @(negedge clk);
        m_ready = 1'b0; m_rdata = 32'h5A5A_5A5A; m_error = 1'b0;
    endtask

    initial begin
        int cyc;
        vec_t v;
        rstn = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        req_prot = '0; req_sels = '0; req_write = '0;
        m_ready = 1'b0; m_rdata = '0; m_error = 1'b0;

        for (int i = 0; i < 8; i++)
            tbl[i] = mk(4'b1111, i % 4, 1'(i), 32'h200 + 32'(i*4), 32'hA000_0000 + 32'(i),
                        i % 3, 32'h5000 + 32'(i), 1'b0);
        tbl[8]  = mk(4'b0100, 2, 1'b1, 32'h100, 32'hDEAD_BEEF, 2, 32'h0,         1'b0);
        tbl[9]  = mk(4'b1111, 3, 1'b0, 32'h40,  32'h0,         1, 32'h1234_5678, 1'b1);
        tbl[10] = mk(4'b1111, 0, 1'b0, 32'h44,  32'h0,         0, 32'h0BAD_F00D, 1'b0);
        tbl[11] = mk(4'b0011, 1, 1'b1, 32'h48,  32'h1111_2222, 0, 32'h0,         1'b0);
        tbl[12] = mk(4'b0011, 0, 1'b1, 32'h4C,  32'h3333_4444, 3, 32'h0,         1'b1);
        tbl[13] = mk(4'b1000, 3, 1'b0, 32'h50,  32'h0,         0, 32'h7777_8888, 1'b0);
        tbl[14] = mk(4'b1001, 0, 1'b0, 32'h54,  32'h0,         1, 32'h9999_AAAA, 1'b0);
        tbl[15] = mk(4'b1001, 3, 1'b1, 32'h58,  32'hBBBB_CCCC, 0, 32'h0,         1'b0);

        repeat (3) @(negedge clk);
        chk("rst_m_valid",   64'(m_valid),   64'd0);
        chk("rst_req_done",  64'(req_done),  64'd0);
        chk("rst_req_rdata", 64'(req_rdata), 64'd0);
        chk("rst_req_error", 64'(req_error), 64'd0);
        chk("rst_m_addr",    64'(m_addr),    64'd0);
        chk("rst_m_abort",   64'(m_abort),   64'd0);
        chk("rst_grant_id",  64'(grant_id),  64'd0);
        rstn = 1'b1;

        // Table-driven transfers.
        for (int k = 0; k < 16; k++) begin
            v = tbl[k];
            req_valid = v.mask;
            set_fields(v);
            wait_mvalid(cyc);
            chk("issue_latency", 64'(cyc), (k == 0) ? 64'd1 : 64'd2);
            chk("grant_id", 64'(grant_id), 64'(v.exp));
            chk("m_addr",   64'(m_addr),   64'(v.addr));
            chk("m_wdata",  64'(m_wdata),  64'(v.wdata));
            chk("m_write",  64'(m_write),  64'(v.wr));
            chk("m_strb",   64'(m_strb),   64'(4'b0001 << v.exp));
            chk("m_prot",   64'(m_prot),   64'(v.exp));
            chk("m_sels",   64'(m_sels),   64'(v.exp + 1));
            for (int w = 0; w < v.waits; w++) begin
                @(negedge clk);
                chk("m_valid_hold", 64'(m_valid), 64'd1);
            end
            pulse_ready(v.rdata, v.err);
            chk("req_done",  64'(req_done),  64'(4'b0001 << v.exp));
            chk("req_rdata", 64'(req_rdata), 64'(v.rdata));
            chk("req_error", 64'(req_error), 64'(v.err));
            chk("m_valid_resp", 64'(m_valid), 64'd0);
        end
        req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_valid", 64'(m_valid), 64'd0);
            chk("idle_no_done",  64'(req_done), 64'd0);
        end

        // Command fields are frozen once granted (last=3, so 0 wins).
        req_valid = 4'b0001;
        req_addr[0 +: AW] = 32'h10;
        req_write[0] = 1'b0;
        wait_mvalid(cyc);
        chk("freeze_addr0", 64'(m_addr), 64'h10);
        req_addr[0 +: AW] = 32'h20;
        req_wdata[0 +: DW] = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("freeze_addr", 64'(m_addr), 64'h10);
        end
        pulse_ready(32'hCAFE_0001, 1'b0);
        req_valid = '0;
        chk("freeze_done",  64'(req_done),  64'h1);
        chk("freeze_rdata", 64'(req_rdata), 64'hCAFE_0001);
        @(negedge clk);
        chk("done_one_cycle", 64'(req_done), 64'd0);

        // Request withdrawn after grant still completes (last=0, 2 wins).
        req_valid = 4'b0100;
        wait_mvalid(cyc);
        chk("withdraw_grant", 64'(grant_id), 64'd2);
        req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            chk("withdraw_hold", 64'(m_valid), 64'd1);
        end
        pulse_ready(32'h0000_00AB, 1'b0);
        chk("withdraw_done", 64'(req_done), 64'h4);

        // Reset in BUSY drops the transfer; next grant goes to requester 0.
        req_valid = 4'b0010;
        set_fields(mk(4'b0010, 1, 1'b1, 32'h300, 32'h1357_9BDF, 0, 32'h0, 1'b0));
        wait_mvalid(cyc);
        chk("pre_reset_grant", 64'(grant_id), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid",  64'(m_valid),   64'd0);
        chk("mid_rst_grant",    64'(grant_id),  64'd0);
        chk("mid_rst_done",     64'(req_done),  64'd0);
        chk("mid_rst_m_addr",   64'(m_addr),    64'd0);
        chk("mid_rst_m_wdata",  64'(m_wdata),   64'd0);
        chk("mid_rst_m_write",  64'(m_write),   64'd0);
        chk("mid_rst_m_sels",   64'(m_sels),    64'd0);
        chk("mid_rst_rdata",    64'(req_rdata), 64'd0);
        chk("mid_rst_error",    64'(req_error), 64'd0);
        chk("mid_rst_abort",    64'(m_abort),   64'd0);
        rstn = 1'b1;
        req_valid = 4'b1111;
        set_fields(mk(4'b1111, 0, 1'b0, 32'h400, 32'h0, 0, 32'h0, 1'b0));
        m_ready = 1'b1;                 // arrives in IDLE: must be ignored
        @(negedge clk);
        m_ready = 1'b0;
        chk("post_rst_valid", 64'(m_valid),  64'd1);
        chk("post_rst_grant", 64'(grant_id), 64'd0);
        chk("ignored_ready",  64'(req_done), 64'd0);
        chk("post_rst_addr",  64'(m_addr),   64'h400);
        req_valid = 4'b0001;
        pulse_ready(32'h2468_ACE0, 1'b0);
        req_valid = '0;
        chk("post_rst_done", 64'(req_done), 64'h1);

        // Stalled master (last=0, requester 1 wins).
        req_valid = 4'b0010;
        wait_mvalid(cyc);
        chk("stall_grant", 64'(grant_id), 64'd1);
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 2; i <= TMO; i++) begin
            @(negedge clk);
            chk("tmo_busy_valid", 64'(m_valid), 64'd1);
            chk("tmo_no_abort",   64'(m_abort), 64'd0);
        end
        @(negedge clk);
        chk("tmo_abort", 64'(m_abort),   64'd1);
        chk("tmo_done",  64'(req_done),  64'h2);
        chk("tmo_error", 64'(req_error), 64'd1);
        chk("tmo_rdata", 64'(req_rdata), 64'd0);
        chk("tmo_valid", 64'(m_valid),   64'd0);
        req_valid = '0;
        @(negedge clk);
        chk("tmo_abort_pulse", 64'(m_abort), 64'd0);
`else
        repeat (40) @(negedge clk);
        chk("stall_valid", 64'(m_valid),  64'd1);
        chk("stall_abort", 64'(m_abort),  64'd0);
        chk("stall_done",  64'(req_done), 64'd0);
        pulse_ready(32'h0F0F_0F0F, 1'b0);
        req_valid = '0;
        chk("stall_done_end", 64'(req_done), 64'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1);
    end

endmodule
